// File: rtl/obi_rr_arbiter_if.sv
// Bundle of N requester-side req/gnt/rvalid channels plus the single merged downstream channel.
// Modport slave is the arbiter's view; master is the surrounding system (requesters and memory).
interface obi_rr_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [N_PORTS-1:0]        m_req;
  logic [N_PORTS-1:0]        m_we;
  logic [N_PORTS*BE_W-1:0]   m_be;
  logic [N_PORTS*ADDR_W-1:0] m_addr;
  logic [N_PORTS*DATA_W-1:0] m_wdata;
  logic [N_PORTS-1:0]        m_gnt;
  logic [N_PORTS-1:0]        m_rvalid;
  logic [DATA_W-1:0]         m_rdata;

  logic                      s_req;
  logic                      s_we;
  logic [BE_W-1:0]           s_be;
  logic [ADDR_W-1:0]         s_addr;
  logic [DATA_W-1:0]         s_wdata;
  logic                      s_gnt;
  logic                      s_rvalid;
  logic [DATA_W-1:0]         s_rdata;

  modport slave (
    input  m_req, m_we, m_be, m_addr, m_wdata, s_gnt, s_rvalid, s_rdata,
    output m_gnt, m_rvalid, m_rdata, s_req, s_we, s_be, s_addr, s_wdata
  );

  modport master (
    output m_req, m_we, m_be, m_addr, m_wdata, s_gnt, s_rvalid, s_rdata,
    input  m_gnt, m_rvalid, m_rdata, s_req, s_we, s_be, s_addr, s_wdata
  );
endinterface

// File: rtl/obi_rr_arbiter.sv
// N-to-1 req/gnt/rvalid arbiter (round-robin or fixed priority); zero-cycle grant, responses routed in order.
// Backpressure: a stalled request is locked until s_gnt; s_req is withheld while the ID FIFO is full.
module obi_rr_arbiter #(
  parameter int N_PORTS   = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2,
  parameter int MODE      = 0
) (
  input  logic             clk,
  input  logic             res,
  obi_rr_arbiter_if.slave  bus,
  output logic             err
);
  localparam int BE_W = DATA_W / 8;
  localparam int PW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int AW   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW   = $clog2(MAX_OUTST + 1);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] sel_q;
  logic          lock;
  logic [PW-1:0] sel_c;
  logic [PW-1:0] sel;

  logic [PW-1:0] id_mem [MAX_OUTST];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [PW-1:0] head;

  logic          s_req_c;
  logic          hs;
  logic          pop;
  logic          rsp_ok;

  function automatic logic [PW-1:0] rr_pick(input logic [N_PORTS-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] idx;
    rr_pick = '0;
    // Walk backwards so the port closest to the pointer is the last one kept.
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      idx = PW'((int'(p) + k) % N_PORTS);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [PW-1:0] fp_pick(input logic [N_PORTS-1:0] r);
    fp_pick = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (r[PW'(k)]) fp_pick = PW'(k);
    end
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    ptr_inc = (p == AW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    sel_c = (MODE == 0) ? rr_pick(bus.m_req, rr_ptr) : fp_pick(bus.m_req);
  end

  assign sel     = lock ? sel_q : sel_c;
  assign full    = (count == CW'(MAX_OUTST));
  assign empty   = (count == '0);
  assign head    = id_mem[rd_ptr];

  // Full gating deliberately ignores a same-cycle pop to keep the grant path short.
  assign s_req_c = res && (|bus.m_req) && !full;
  assign hs      = s_req_c && bus.s_gnt;
  assign pop     = bus.s_rvalid && !empty;
  assign rsp_ok  = res && pop;

  assign bus.s_req   = s_req_c;
  assign bus.m_rdata = bus.s_rdata;

  always_comb begin
    bus.s_we    = bus.m_we[0];
    bus.s_be    = bus.m_be[BE_W-1:0];
    bus.s_addr  = bus.m_addr[ADDR_W-1:0];
    bus.s_wdata = bus.m_wdata[DATA_W-1:0];
    if (s_req_c) begin
      bus.s_we    = bus.m_we[sel];
      bus.s_be    = bus.m_be[int'(sel)*BE_W +: BE_W];
      bus.s_addr  = bus.m_addr[int'(sel)*ADDR_W +: ADDR_W];
      bus.s_wdata = bus.m_wdata[int'(sel)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    bus.m_gnt    = '0;
    bus.m_rvalid = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      bus.m_gnt[i]    = hs && (sel == PW'(i));
      bus.m_rvalid[i] = rsp_ok && (head == PW'(i));
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rr_ptr <= '0;
      sel_q  <= '0;
      lock   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      // Hold the stalled choice so downstream address/data stay stable until granted.
      if (hs) begin
        lock <= 1'b0;
        if (MODE == 0) begin
          rr_ptr <= (sel == PW'(N_PORTS - 1)) ? '0 : sel + 1'b1;
        end
      end else if (s_req_c) begin
        lock  <= 1'b1;
        sel_q <= sel;
      end

      if (hs)  wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);

      case ({hs, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (bus.s_rvalid && empty) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (hs) id_mem[wr_ptr] <= sel;
  end
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed bench: a 2-port round-robin instance and a 4-port fixed-priority instance share clock and reset.
module tb_obi_rr_arbiter;
  logic clk = 1'b0;
  logic res;
  logic err0;
  logic err1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  obi_rr_arbiter_if #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32)) a ();
  obi_rr_arbiter_if #(.N_PORTS(4), .ADDR_W(32), .DATA_W(32)) b ();

  obi_rr_arbiter #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(2), .MODE(0)) u_rr (
    .clk (clk),
    .res (res),
    .bus (a),
    .err (err0)
  );

  obi_rr_arbiter #(.N_PORTS(4), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(2), .MODE(1)) u_fp (
    .clk (clk),
    .res (res),
    .bus (b),
    .err (err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a.m_req = '0; a.m_we = '0; a.m_be = '0; a.m_addr = '0; a.m_wdata = '0;
    a.s_gnt = 1'b0; a.s_rvalid = 1'b0; a.s_rdata = '0;
    b.m_req = '0; b.m_we = '0; b.m_be = '0; b.m_addr = '0; b.m_wdata = '0;
    b.s_gnt = 1'b0; b.s_rvalid = 1'b0; b.s_rdata = '0;
  endtask

  initial begin
    res = 1'b1;
    idle();
    #1 res = 1'b0;
    // Reset forces the handshake outputs low even with active inputs.
    a.m_req = 2'b11; a.s_gnt = 1'b1; a.s_rvalid = 1'b1;
    b.m_req = 4'hF;  b.s_gnt = 1'b1;
    #2;
    chk("rst_s_req",   32'(a.s_req), 32'd0);
    chk("rst_m_gnt",   32'(a.m_gnt), 32'd0);
    chk("rst_rvalid",  32'(a.m_rvalid), 32'd0);
    chk("rst_err",     32'(err0), 32'd0);
    chk("rst_b_s_req", 32'(b.s_req), 32'd0);
    idle();
    nxt();
    res = 1'b1;

    // Single port read.
    a.m_req = 2'b01; a.m_addr[31:0] = 32'h100; a.s_gnt = 1'b1;
    @(negedge clk);
    chk("t1_s_req",  32'(a.s_req), 32'd1);
    chk("t1_s_addr", a.s_addr, 32'h100);
    chk("t1_m_gnt",  32'(a.m_gnt), 32'd1);
    nxt();
    a.m_req = 2'b00; a.s_gnt = 1'b0; a.s_rvalid = 1'b1; a.s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_rvalid", 32'(a.m_rvalid), 32'd1);
    chk("t1_rdata",  a.m_rdata, 32'hDEADBEEF);
    chk("t1_gnt_0",  32'(a.m_gnt), 32'd0);
    nxt();
    a.s_rvalid = 1'b0;
    @(negedge clk);
    chk("t1_err", 32'(err0), 32'd0);
    nxt();
    res = 1'b0;
    nxt();
    res = 1'b1;

    // Round-robin fairness with one-cycle responses.
    a.m_req = 2'b11; a.s_gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a.s_rvalid = (i > 0);
      a.s_rdata  = 32'hA0 + 32'(i);
      @(negedge clk);
      chk("rr_gnt", 32'(a.m_gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i > 0) chk("rr_rsp", 32'(a.m_rvalid), (i % 2 == 0) ? 32'd2 : 32'd1);
      nxt();
    end
    a.m_req = 2'b00; a.s_gnt = 1'b0; a.s_rvalid = 1'b1; a.s_rdata = 32'hA6;
    @(negedge clk);
    chk("rr_last_rsp",   32'(a.m_rvalid), 32'd2);
    chk("rr_last_rdata", a.m_rdata, 32'hA6);
    nxt();
    a.s_rvalid = 1'b0;

    // Lock under backpressure: port 1 stalled, port 0 joins later.
    a.m_req   = 2'b10;
    a.m_addr  = {32'h200, 32'h300};
    a.m_we    = 2'b10;
    a.m_wdata = {32'hCAFE0001, 32'h0};
    a.m_be    = {4'hC, 4'hF};
    for (int c = 0; c < 3; c++) begin
      if (c == 1) a.m_req = 2'b11;
      @(negedge clk);
      chk("lk_s_addr", a.s_addr, 32'h200);
      chk("lk_m_gnt",  32'(a.m_gnt), 32'd0);
      chk("lk_s_req",  32'(a.s_req), 32'd1);
      nxt();
    end
    a.s_gnt = 1'b1;
    @(negedge clk);
    chk("lk_gnt_p1",  32'(a.m_gnt), 32'd2);
    chk("lk_addr_p1", a.s_addr, 32'h200);
    chk("lk_we_p1",   32'(a.s_we), 32'd1);
    chk("lk_wdat_p1", a.s_wdata, 32'hCAFE0001);
    chk("lk_be_p1",   32'(a.s_be), 32'hC);
    nxt();
    a.m_req = 2'b01;
    @(negedge clk);
    chk("lk_gnt_p0",  32'(a.m_gnt), 32'd1);
    chk("lk_addr_p0", a.s_addr, 32'h300);
    chk("lk_we_p0",   32'(a.s_we), 32'd0);
    nxt();

    // Two outstanding: request withheld until a response drains a slot.
    @(negedge clk);
    chk("full_s_req", 32'(a.s_req), 32'd0);
    chk("full_m_gnt", 32'(a.m_gnt), 32'd0);
    nxt();
    a.s_rvalid = 1'b1; a.s_rdata = 32'h11;
    @(negedge clk);
    chk("full_rsp_p1",   32'(a.m_rvalid), 32'd2);
    chk("full_pop_sreq", 32'(a.s_req), 32'd0);
    nxt();
    a.s_rvalid = 1'b0;
    @(negedge clk);
    chk("refill_s_req", 32'(a.s_req), 32'd1);
    chk("refill_m_gnt", 32'(a.m_gnt), 32'd1);
    nxt();
    a.m_req = 2'b00; a.s_gnt = 1'b0; a.s_rvalid = 1'b1;
    @(negedge clk);
    chk("drain_rsp0", 32'(a.m_rvalid), 32'd1);
    nxt();
    @(negedge clk);
    chk("drain_rsp1", 32'(a.m_rvalid), 32'd1);
    nxt();
    a.s_rvalid = 1'b0;
    @(negedge clk);
    chk("drain_err", 32'(err0), 32'd0);

    // Stray response with nothing outstanding.
    a.s_rvalid = 1'b1;
    @(negedge clk);
    chk("stray_rvalid", 32'(a.m_rvalid), 32'd0);
    nxt();
    a.s_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_err", 32'(err0), 32'd1);
    nxt();

    // Reset with two transactions in flight drops them.
    a.m_req = 2'b01; a.s_gnt = 1'b1;
    nxt();
    nxt();
    a.m_req = 2'b00; a.s_gnt = 1'b0;
    chk("err_sticky", 32'(err0), 32'd1);
    res = 1'b0;
    #1;
    chk("arst_err", 32'(err0), 32'd0);
    nxt();
    res = 1'b1;
    a.s_rvalid = 1'b1;
    @(negedge clk);
    chk("post_rst_rvalid", 32'(a.m_rvalid), 32'd0);
    nxt();
    a.s_rvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_err", 32'(err0), 32'd1);
    nxt();

    // Fixed priority, four ports: port 1 beats port 3.
    b.m_req = 4'b1010; b.s_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b.s_rvalid = (i > 0);
      @(negedge clk);
      chk("fp_gnt", 32'(b.m_gnt), 32'h2);
      if (i > 0) chk("fp_rsp", 32'(b.m_rvalid), 32'h2);
      nxt();
    end
    b.m_req = 4'b1000; b.s_rvalid = 1'b1;
    @(negedge clk);
    chk("fp_gnt_p3", 32'(b.m_gnt), 32'h8);
    chk("fp_rsp_p1", 32'(b.m_rvalid), 32'h2);
    nxt();
    b.m_req = 4'b0000; b.s_gnt = 1'b0;
    @(negedge clk);
    chk("fp_rsp_p3", 32'(b.m_rvalid), 32'h8);
    nxt();
    b.s_rvalid = 1'b0;
    @(negedge clk);
    chk("fp_err", 32'(err1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
